// File: rtl/conv2d_3x3_pkg.sv
// Shared types and width helpers for the 3x3 convolution engine.
package conv2d_3x3_pkg;

    typedef enum logic [1:0] {LOAD, WAIT_K, COMPUTE, OUTPUT} state_e;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int kernel_depth(input int filters, input int in_ch,
                                        input int word_w, input int buf_w);
        return 9 * filters * in_ch * word_w / buf_w;
    endfunction

endpackage

// File: rtl/conv2d_3x3_if.sv
// Image, kernel and result streams of the convolution engine, named from the engine's side.
interface conv2d_3x3_if #(
    parameter int WORD_WIDTH         = 8,
    parameter int WORDS_PER_TRANSFER = 2,
    parameter int KERNEL_BUF_WIDTH   = 64
);
    localparam int OUT_WIDTH = KERNEL_BUF_WIDTH / WORDS_PER_TRANSFER;

    logic                                     i_img_tvalid;
    logic                                     o_img_tready;
    logic [WORD_WIDTH*WORDS_PER_TRANSFER-1:0] i_img_tdata;
    logic                                     i_kernel_tvalid;
    logic                                     o_kernel_tready;
    logic [KERNEL_BUF_WIDTH-1:0]              i_kernel_tdata;
    logic                                     i_out_tready;
    logic                                     o_out_tvalid;
    logic [OUT_WIDTH-1:0]                     o_out_tdata;

    modport slave (
        input  i_img_tvalid, i_img_tdata, i_kernel_tvalid, i_kernel_tdata, i_out_tready,
        output o_img_tready, o_kernel_tready, o_out_tvalid, o_out_tdata
    );

    modport master (
        output i_img_tvalid, i_img_tdata, i_kernel_tvalid, i_kernel_tdata, i_out_tready,
        input  o_img_tready, o_kernel_tready, o_out_tvalid, o_out_tdata
    );
endinterface

// File: rtl/conv2d_3x3_mac.sv
// Signed multiply-accumulate; operands sign-extended, sum wraps at AW bits.
module conv2d_3x3_mac #(
    parameter int WW = 8,
    parameter int AW = 32
) (
    input  logic                 i_aclk,
    input  logic                 i_aresetn,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [WW-1:0] a,
    input  logic signed [WW-1:0] b,
    output logic signed [AW-1:0] acc
);
    logic signed [2*WW-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + AW'(prod);
    end
endmodule

// File: rtl/conv2d_3x3.sv
// Streaming 3x3 "same"-padded convolution: weights loaded once, frames buffered then
// convolved one MAC per cycle, results streamed pixel-raster with filter inner.
module conv2d_3x3
    import conv2d_3x3_pkg::*;
#(
    parameter int IMG_HEIGHT          = 5,
    parameter int IMG_WIDTH           = 4,
    parameter int TRANSFERS_PER_PIXEL = 2,
    parameter int WORDS_PER_TRANSFER  = 2,
    parameter int FILTERS             = 8,
    parameter int WORD_WIDTH          = 8,
    parameter int KERNEL_BUF_WIDTH    = 64
) (
    input logic         i_aclk,
    input logic         i_aresetn,
    conv2d_3x3_if.slave bus
);
    localparam int IN_CHANNEL   = TRANSFERS_PER_PIXEL * WORDS_PER_TRANSFER;
    localparam int OUT_WIDTH    = KERNEL_BUF_WIDTH / WORDS_PER_TRANSFER;
    localparam int KERNEL_DEPTH = kernel_depth(FILTERS, IN_CHANNEL, WORD_WIDTH, KERNEL_BUF_WIDTH);
    localparam int TAPS         = 9 * IN_CHANNEL;
    localparam int WPB          = KERNEL_BUF_WIDTH / WORD_WIDTH;
    localparam int FRAME_BEATS  = IMG_HEIGHT * IMG_WIDTH * TRANSFERS_PER_PIXEL;
    localparam int BEAT_W       = WORD_WIDTH * WORDS_PER_TRANSFER;
    localparam int KAW          = addr_w(KERNEL_DEPTH);
    localparam int FAW          = addr_w(FRAME_BEATS);
    localparam int TW           = addr_w(TAPS + 2);
    localparam int RW           = addr_w(IMG_HEIGHT);
    localparam int CW           = addr_w(IMG_WIDTH);
    localparam int FW           = addr_w(FILTERS);
    localparam int KSW          = addr_w(WPB);
    localparam int FSW          = addr_w(WORDS_PER_TRANSFER);

    state_e                state;
    logic                  img_rdy, k_rdy, out_vld, rd_vld;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [KAW-1:0]        k_cnt;
    logic [FAW-1:0]        f_cnt;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [FW-1:0]         filt;
    logic [TW-1:0]         tap;

    logic                  k_hs, i_hs, o_hs, issue;
    logic [KERNEL_BUF_WIDTH-1:0] kmem [KERNEL_DEPTH];
    logic [BEAT_W-1:0]     fmem [FRAME_BEATS];
    logic [KERNEL_BUF_WIDTH-1:0] k_q;
    logic [BEAT_W-1:0]     f_q;
    logic                  pad, pad_q;
    logic [KAW-1:0]        k_addr;
    logic [FAW-1:0]        f_addr;
    logic [KSW-1:0]        ksel, ksel_q;
    logic [FSW-1:0]        fsel, fsel_q;
    logic signed [WORD_WIDTH-1:0] mac_a, mac_b;
    logic signed [OUT_WIDTH-1:0]  acc;
    int t_ch, t_kx, t_ky, t_r, t_c, w_idx;

    assign k_hs  = bus.i_kernel_tvalid & k_rdy;
    assign i_hs  = bus.i_img_tvalid & img_rdy & (state == LOAD);
    assign o_hs  = out_vld & bus.i_out_tready;
    assign issue = (state == COMPUTE) && (tap < TW'(TAPS));

    assign bus.o_img_tready    = img_rdy;
    assign bus.o_kernel_tready = k_rdy;
    assign bus.o_out_tvalid    = out_vld;
    assign bus.o_out_tdata     = out_data;

    // Tap order is ky, kx, ch (ch fastest), matching the flat weight layout.
    always_comb begin
        t_ch   = int'(tap) % IN_CHANNEL;
        t_kx   = (int'(tap) / IN_CHANNEL) % 3;
        t_ky   = int'(tap) / (3 * IN_CHANNEL);
        t_r    = int'(row) + t_ky - 1;
        t_c    = int'(col) + t_kx - 1;
        w_idx  = int'(filt) * TAPS + int'(tap);
        pad    = (t_r < 0) || (t_r >= IMG_HEIGHT) || (t_c < 0) || (t_c >= IMG_WIDTH);
        k_addr = KAW'(w_idx / WPB);
        ksel   = KSW'(w_idx % WPB);
        f_addr = FAW'((t_r * IMG_WIDTH + t_c) * TRANSFERS_PER_PIXEL + t_ch / WORDS_PER_TRANSFER);
        fsel   = FSW'(t_ch % WORDS_PER_TRANSFER);
    end

    // Buffers carry no reset; padded taps read an arbitrary word that is masked below.
    always_ff @(posedge i_aclk) begin
        if (k_hs)
            kmem[k_cnt] <= bus.i_kernel_tdata;
        if (i_hs)
            fmem[f_cnt] <= bus.i_img_tdata;
        k_q    <= kmem[k_addr];
        f_q    <= fmem[f_addr];
        pad_q  <= pad;
        ksel_q <= ksel;
        fsel_q <= fsel;
    end

    assign mac_a = pad_q ? '0 : f_q[fsel_q*WORD_WIDTH +: WORD_WIDTH];
    assign mac_b = k_q[ksel_q*WORD_WIDTH +: WORD_WIDTH];

    conv2d_3x3_mac #(.WW(WORD_WIDTH), .AW(OUT_WIDTH)) u_mac (
        .i_aclk    (i_aclk),
        .i_aresetn (i_aresetn),
        .clr       ((state == COMPUTE) && (tap == '0)),
        .en        (rd_vld),
        .a         (mac_a),
        .b         (mac_b),
        .acc       (acc)
    );

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            state    <= LOAD;
            img_rdy  <= 1'b1;
            k_rdy    <= 1'b1;
            out_vld  <= 1'b0;
            out_data <= '0;
            rd_vld   <= 1'b0;
            k_cnt    <= '0;
            f_cnt    <= '0;
            row      <= '0;
            col      <= '0;
            filt     <= '0;
            tap      <= '0;
        end else begin
            rd_vld <= issue;
            if (k_hs) begin
                k_cnt <= k_cnt + 1'b1;
                if (k_cnt == KAW'(KERNEL_DEPTH - 1))
                    k_rdy <= 1'b0;
            end
            case (state)
                LOAD: begin
                    if (i_hs) begin
                        f_cnt <= f_cnt + 1'b1;
                        if (f_cnt == FAW'(FRAME_BEATS - 1)) begin
                            f_cnt   <= '0;
                            img_rdy <= 1'b0;
                            state   <= WAIT_K;
                        end
                    end
                end
                WAIT_K: begin
                    if (!k_rdy) begin
                        tap   <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // Two extra cycles drain the read register and the final accumulate.
                    if (tap == TW'(TAPS + 1)) begin
                        out_data <= acc;
                        out_vld  <= 1'b1;
                        state    <= OUTPUT;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (o_hs) begin
                        out_vld <= 1'b0;
                        tap     <= '0;
                        state   <= COMPUTE;
                        if (filt == FW'(FILTERS - 1)) begin
                            filt <= '0;
                            if (col == CW'(IMG_WIDTH - 1)) begin
                                col <= '0;
                                if (row == RW'(IMG_HEIGHT - 1)) begin
                                    row     <= '0;
                                    img_rdy <= 1'b1;
                                    state   <= LOAD;
                                end else begin
                                    row <= row + 1'b1;
                                end
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            filt <= filt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_3x3.sv
// Directed bench for conv2d_3x3: kernel load, frames, stalls and mid-compute reset.
module tb_conv2d_3x3;
    localparam int H = 5, W = 4, TPP = 2, WPT = 2, F = 8, WW = 8, KBW = 64;
    localparam int IC = TPP * WPT, KD = 36, NRES = H * W * F, NBEATS = H * W * TPP;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    conv2d_3x3_if #(.WORD_WIDTH(WW), .WORDS_PER_TRANSFER(WPT), .KERNEL_BUF_WIDTH(KBW)) bus ();

    conv2d_3x3 #(
        .IMG_HEIGHT(H), .IMG_WIDTH(W), .TRANSFERS_PER_PIXEL(TPP), .WORDS_PER_TRANSFER(WPT),
        .FILTERS(F), .WORD_WIDTH(WW), .KERNEL_BUF_WIDTH(KBW)
    ) dut (
        .i_aclk    (clk),
        .i_aresetn (rstn),
        .bus       (bus)
    );

    int checks = 0, failures = 0;
    int got [NRES];
    int ngot, hold_err, lat;

    function automatic int img_word(input int mode, input int n);
        logic signed [7:0] b;
        if (mode == 0) return n;
        b = 8'(n * 37 + 5);
        return int'(b);
    endfunction

    function automatic int wt(input int mode, input int idx);
        if (mode == 0) return 1;
        return (idx % 7) - 3;
    endfunction

    function automatic int model(input int im, input int wm, input int r, input int c, input int f);
        int s = 0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
                for (int ch = 0; ch < IC; ch++) begin
                    int rr = r + ky - 1, cc = c + kx - 1;
                    if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                        s += img_word(im, (rr * W + cc) * IC + ch) * wt(wm, ((f * 3 + ky) * 3 + kx) * IC + ch);
                end
        return s;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_kernel(input int wm, output int not_rdy, output bit to);
        int k = 0, cyc = 0;
        logic [KBW-1:0] d;
        not_rdy = 0;
        while (k < KD && cyc < 200) begin
            for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(wt(wm, k * 8 + j));
            bus.i_kernel_tvalid = 1'b1;
            bus.i_kernel_tdata  = d;
            if (bus.o_kernel_tready === 1'b1) k++; else not_rdy++;
            @(posedge clk); #1; cyc++;
        end
        bus.i_kernel_tvalid = 1'b0;
        to = (k < KD);
    endtask

    task automatic send_frame(input int im, output bit to);
        int b = 0, cyc = 0;
        logic rdy;
        while (b < NBEATS && cyc < 1000) begin
            for (int j = 0; j < WPT; j++) bus.i_img_tdata[j*8 +: 8] = 8'(img_word(im, b * WPT + j));
            bus.i_img_tvalid = 1'b1;
            rdy = bus.o_img_tready;
            @(posedge clk); #1; cyc++;
            if (rdy === 1'b1) begin
                b++;
                if (b < NBEATS) begin
                    bus.i_img_tvalid = 1'b0;
                    bus.i_img_tdata  = '1;
                    @(posedge clk); #1; cyc++;
                end
            end
        end
        bus.i_img_tvalid = 1'b0;
        to = (b < NBEATS);
    endtask

    task automatic collect(input bit stall, output bit to);
        int cyc = 0;
        bit pv = 0, pr = 0;
        logic [31:0] pd = '0;
        ngot = 0; hold_err = 0; lat = -1;
        while (ngot < NRES && cyc < 20000) begin
            bus.i_out_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && !pr && (bus.o_out_tvalid !== 1'b1 || bus.o_out_tdata !== pd)) hold_err++;
            if (lat < 0 && bus.o_out_tvalid === 1'b1) lat = cyc;
            pv = bus.o_out_tvalid;
            pr = bus.i_out_tready;
            pd = bus.o_out_tdata;
            if (pv && pr) begin got[ngot] = int'(pd); ngot++; end
            @(posedge clk); #1; cyc++;
        end
        bus.i_out_tready = 1'b0;
        to = (ngot < NRES);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (bus.o_img_tready !== 1'b1) begin failures++; $display("FAIL reset_img_tready got=%b exp=1", bus.o_img_tready); end
        if (bus.o_kernel_tready !== 1'b1) begin failures++; $display("FAIL reset_kernel_tready got=%b exp=1", bus.o_kernel_tready); end
        if (bus.o_out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_out_tvalid got=%b exp=0", bus.o_out_tvalid); end
        if (bus.o_out_tdata !== 32'd0) begin failures++; $display("FAIL reset_out_tdata got=%0h exp=0", bus.o_out_tdata); end
    endtask

    task automatic test_kernel_load(input int wm);
        int nr; bit to;
        send_kernel(wm, nr, to);
        checks += 3;
        if (to) begin failures++; $display("FAIL kernel_timeout got=1 exp=0"); end
        if (nr != 0) begin failures++; $display("FAIL kernel_tready_gaps got=%0d exp=0", nr); end
        if (bus.o_kernel_tready !== 1'b0) begin failures++; $display("FAIL kernel_tready_after got=%b exp=0", bus.o_kernel_tready); end
        bus.i_kernel_tdata = '1;
        bus.i_kernel_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.o_kernel_tready !== 1'b0) begin failures++; $display("FAIL kernel_extra_beat%0d got=%b exp=0", i, bus.o_kernel_tready); end
        end
        bus.i_kernel_tvalid = 1'b0;
    endtask

    task automatic check_results(input string name, input int im, input int wm);
        for (int p = 0; p < H * W; p++)
            for (int f = 0; f < F; f++) begin
                int e = model(im, wm, p / W, p % W, f);
                checks++;
                if (got[p * F + f] !== e) begin
                    failures++;
                    $display("FAIL %s pix=(%0d,%0d) f=%0d got=%0d exp=%0d", name, p / W, p % W, f, got[p * F + f], e);
                end
            end
    endtask

    task automatic test_frame();
        bit to;
        send_frame(0, to);
        checks += 2;
        if (to) begin failures++; $display("FAIL frame_send_timeout got=1 exp=0"); end
        if (bus.o_img_tready !== 1'b0) begin failures++; $display("FAIL img_tready_after_frame got=%b exp=0", bus.o_img_tready); end
        collect(0, to);
        checks += 6;
        if (to) begin failures++; $display("FAIL frame_collect_timeout got=%0d exp=%0d", ngot, NRES); end
        if (lat != 9 * IC + 3) begin failures++; $display("FAIL first_result_latency got=%0d exp=%0d", lat, 9 * IC + 3); end
        if (got[0] !== 184) begin failures++; $display("FAIL pix00 got=%0d exp=184", got[0]); end
        if (got[9 * F + 3] !== 1350) begin failures++; $display("FAIL pix21 got=%0d exp=1350", got[9 * F + 3]); end
        if (got[19 * F + 7] !== 1080) begin failures++; $display("FAIL pix43 got=%0d exp=1080", got[19 * F + 7]); end
        if (bus.o_img_tready !== 1'b1) begin failures++; $display("FAIL img_tready_after_output got=%b exp=1", bus.o_img_tready); end
        check_results("frame1", 0, 0);
    endtask

    task automatic test_back_to_back();
        bit to1, to2;
        send_frame(0, to1);
        collect(0, to2);
        checks += 2;
        if (to1 || to2) begin failures++; $display("FAIL frame2_timeout got=%0d exp=%0d", ngot, NRES); end
        if (bus.o_img_tready !== 1'b1) begin failures++; $display("FAIL frame2_img_tready got=%b exp=1", bus.o_img_tready); end
        check_results("frame2", 0, 0);
    endtask

    task automatic test_stall();
        bit to1, to2;
        send_frame(0, to1);
        collect(1, to2);
        checks += 2;
        if (to1 || to2) begin failures++; $display("FAIL stall_timeout got=%0d exp=%0d", ngot, NRES); end
        if (hold_err != 0) begin failures++; $display("FAIL stall_hold got=%0d exp=0", hold_err); end
        check_results("stall", 0, 0);
    endtask

    task automatic test_reset_mid_compute();
        bit to1, to2;
        send_frame(0, to1);
        repeat (50) @(posedge clk);
        #1;
        do_reset();
        checks += 4;
        if (bus.o_img_tready !== 1'b1) begin failures++; $display("FAIL midrst_img_tready got=%b exp=1", bus.o_img_tready); end
        if (bus.o_kernel_tready !== 1'b1) begin failures++; $display("FAIL midrst_kernel_tready got=%b exp=1", bus.o_kernel_tready); end
        if (bus.o_out_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_out_tvalid got=%b exp=0", bus.o_out_tvalid); end
        if (bus.o_out_tdata !== 32'd0) begin failures++; $display("FAIL midrst_out_tdata got=%0h exp=0", bus.o_out_tdata); end
        test_kernel_load(1);
        send_frame(1, to1);
        collect(0, to2);
        checks++;
        if (to1 || to2) begin failures++; $display("FAIL reload_timeout got=%0d exp=%0d", ngot, NRES); end
        check_results("reload", 1, 1);
    endtask

    initial begin
        bus.i_img_tvalid    = 1'b0;
        bus.i_img_tdata     = '0;
        bus.i_kernel_tvalid = 1'b0;
        bus.i_kernel_tdata  = '0;
        bus.i_out_tready    = 1'b0;
        test_reset();
        test_kernel_load(0);
        test_frame();
        test_back_to_back();
        test_stall();
        test_reset_mid_compute();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
